// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the instruction fetch stage and the control
// unit.
//   pcsrc_e       : next-PC select, using the same encoding the control unit
//                   drives (2'b11 is reserved and is treated as PC+4).
//   fetch_state_e : fetch FSM states.
//   NOP_INSTR     : addi x0,x0,0, the value Instr holds out of reset.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_ALU    = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        HOLD  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction memory request/response bus.
//   IMemReq    : fetch request valid          (master -> slave)
//   IMemAddr   : fetch address                (master -> slave)
//   IMemReady  : memory accepts the request   (slave -> master)
//   IMemRValid : read data valid              (slave -> master)
//   IMemRData  : instruction word             (slave -> master)
// The fetch unit is the master and the instruction memory is the slave.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRValid;
    logic [31:0] IMemRData;

    modport master (
        output IMemReq, IMemAddr,
        input  IMemReady, IMemRValid, IMemRData
    );

    modport slave (
        input  IMemReq, IMemAddr,
        output IMemReady, IMemRValid, IMemRData
    );
endinterface

// File: rtl/instr_fetch_unit_pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC selection. All arithmetic wraps modulo 2^32.
//   PC        in  32  current PC
//   ImmExt    in  32  extended immediate (branch/jal offset)
//   ALUResult in  32  jalr target (bit 0 forced to zero)
//   PCSrc     in   2  select, encoded as fetch_pkg::pcsrc_e
//   PCPlus4   out 32  PC + 4
//   PCNext    out 32  selected next PC
// -----------------------------------------------------------------------------
module pc_next_mux
    import fetch_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic [1:0]  PCSrc,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCNext
);

    always_comb begin
        PCPlus4 = PC + 32'd4;
        case (pcsrc_e'(PCSrc))
            PC_TARGET: PCNext = PC + ImmExt;
            PC_ALU:    PCNext = ALUResult & ~32'd1;
            // PC_PLUS4 and the reserved encoding both fall through to PC+4.
            default:   PCNext = PCPlus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// RISC-V fetch stage: holds the architectural PC, issues one instruction
// memory request at a time and presents the returned word to decode.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   PCSrc, ImmExt,      next-PC select and operands, sampled only when the
//   ALUResult           current instruction is consumed
//   Advance             decode consumes the current instruction
//   imem                instruction memory bus (master side)
//   Instr, InstrValid,  instruction presented to decode and its address
//   PC, PCPlus4
//   FetchErr            sticky response timeout flag
//
// Parameters:
//   RESET_PC            PC loaded on reset
//   TIMEOUT_CYCLES      WAIT cycles tolerated before FetchErr (1..65535)
//
// Build option:
//   FETCH_BYPASS_EN     when defined, a response arriving in WAIT is shown to
//                       decode in the same cycle and may be consumed at once.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         PCSrc,
    input  logic [31:0]        ImmExt,
    input  logic [31:0]        ALUResult,
    input  logic               Advance,
    instr_fetch_unit_if.master imem,
    output logic [31:0]        Instr,
    output logic               InstrValid,
    output logic [31:0]        PC,
    output logic [31:0]        PCPlus4,
    output logic               FetchErr
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    fetch_state_e state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  instr_reg;
    logic         valid_reg;
    logic         err_reg;
    logic [15:0]  wait_cnt_reg;

    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         resp_hit;

    pc_next_mux u_pc_next_mux (
        .PC        (pc_reg),
        .ImmExt    (ImmExt),
        .ALUResult (ALUResult),
        .PCSrc     (PCSrc),
        .PCPlus4   (pc_plus4),
        .PCNext    (pc_next)
    );

    // Once timed out the stage is dead until reset, so late data is dropped.
    assign resp_hit = (state_reg == WAIT) && imem.IMemRValid && !err_reg;

    // Request is masked while reset is high so nothing is issued to a memory
    // that is itself being reset.
    assign imem.IMemReq  = (state_reg == FETCH) && !reset;
    assign imem.IMemAddr = pc_reg;
    assign PC            = pc_reg;
    assign PCPlus4       = pc_plus4;
    assign FetchErr      = err_reg;

`ifdef FETCH_BYPASS_EN
    logic bypass_take;
    assign bypass_take = resp_hit && Advance;
    assign Instr       = resp_hit ? imem.IMemRData : instr_reg;
    assign InstrValid  = valid_reg || resp_hit;
`else
    assign Instr       = instr_reg;
    assign InstrValid  = valid_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem.IMemReady) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_hit) begin
                        instr_reg <= imem.IMemRData;
`ifdef FETCH_BYPASS_EN
                        if (bypass_take) begin
                            pc_reg    <= pc_next;
                            state_reg <= FETCH;
                        end else begin
                            valid_reg <= 1'b1;
                            state_reg <= HOLD;
                        end
`else
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
`endif
                    end else if (!err_reg) begin
                        // The error flag rises on the same edge the counter
                        // reaches the limit; the counter then freezes.
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                        if (wait_cnt_reg == TIMEOUT_LAST) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (Advance) begin
                        pc_reg    <= pc_next;
                        valid_reg <= 1'b0;
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule
